shift_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the EX-stage shift unit.
- Decodes the six MIPS R-type shift functs: SLL, SRL, SRA, SLLV, SRLV and SRAV.
- Selects the shift amount: instr shamt field [10:6] for immediate forms, rs[4:0] for variable forms.
- Iterates a narrow STEP-bit shifter until the full amount is applied, and talks to the pipeline through valid/ready handshakes plus a busy stall flag.

---
 rtl/shift_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer for the EX-stage shift unit: decodes the six MIPS R-type
// shift functs and applies the shift STEP bits per cycle behind valid/ready handshakes.
module shift_seq_ctrl #(
    parameter int STEP = 4,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [5:0]   funct,
    input  logic [4:0]   shamt_field,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         busy
);

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] value;
    logic [W-1:0] value_shifted;
    logic [1:0]   op;
    logic [5:0]   rem;
    logic [5:0]   k;
    logic         err_q;
    logic         accept;
    logic         is_imm;
    logic         is_var;
    logic         supported;
    logic [4:0]   amt_in;
    logic         rs_unused;

    assign rs_unused = ^rs[W-1:5];

    assign in_ready  = (state == IDLE) && !rst && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = value;
    assign err       = err_q;

    always_comb begin
        is_imm    = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
        is_var    = (funct == F_SLLV) || (funct == F_SRLV) || (funct == F_SRAV);
        supported = is_imm || is_var;
        amt_in    = 5'd0;
        if (is_imm) begin
            amt_in = shamt_field;
        end else if (is_var) begin
            amt_in = rs[4:0];
        end
    end

    // funct[1:0] encodes the shift kind: 00 left, 10 logical right, 11 arithmetic right
    always_comb begin
        k = (rem < 6'(STEP)) ? rem : 6'(STEP);
        case (op)
            2'b00:   value_shifted = value << k;
            2'b10:   value_shifted = value >> k;
            default: value_shifted = W'($signed(value) >>> k);
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (!supported || amt_in == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem <= 6'(STEP)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush leaves the discarded result in place; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            op    <= 2'b00;
            rem   <= 6'd0;
            err_q <= 1'b0;
        end else if (flush) begin
            rem <= 6'd0;
        end else if (accept) begin
            value <= rt;
            op    <= funct[1:0];
            rem   <= {1'b0, amt_in};
            err_q <= !supported;
        end else if (state == SHIFT) begin
            value <= value_shifted;
            rem   <= rem - k;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl; a STEP=4 and a STEP=1 instance
// share stimulus, with 'sel' choosing which one is driven and observed.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_g, rst_l, flush, in_valid, out_ready, sel;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs, rt;

    logic        rst4, rst1, flush4, flush1, in_valid4, in_valid1;
    logic        in_ready4, in_ready1, out_valid4, out_valid1;
    logic        err4, err1, busy4, busy1;
    logic [31:0] result4, result1;

    logic        obs_in_ready, obs_out_valid, obs_err, obs_busy;
    logic [31:0] obs_result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rst4      = rst_g | (rst_l & ~sel);
    assign rst1      = rst_g | (rst_l & sel);
    assign flush4    = flush & ~sel;
    assign flush1    = flush & sel;
    assign in_valid4 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;

    assign obs_in_ready  = sel ? in_ready1  : in_ready4;
    assign obs_out_valid = sel ? out_valid1 : out_valid4;
    assign obs_err       = sel ? err1       : err4;
    assign obs_busy      = sel ? busy1      : busy4;
    assign obs_result    = sel ? result1    : result4;

    shift_seq_ctrl #(.STEP(4), .W(32)) dut4 (
        .clk(clk), .rst(rst4), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .funct(funct), .shamt_field(shamt), .rs(rs), .rt(rt), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .err(err4), .busy(busy4)
    );

    shift_seq_ctrl #(.STEP(1), .W(32)) dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .funct(funct), .shamt_field(shamt), .rs(rs), .rt(rt), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .err(err1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one op, scrambles the inputs afterwards, and waits (bounded) for out_valid
    task automatic run_op(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] r_s,
                          input logic [31:0] r_t, output int lat, output logic busy_ok);
        funct = f; shamt = sh; rs = r_s; rt = r_t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; funct = 6'h3f; shamt = 5'h1f; rs = 32'hFFFF_FFFF; rt = 32'h5555_AAAA;
        lat = 1;
        busy_ok = 1'b1;
        while (!obs_out_valid && lat < 64) begin
            if (!obs_busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!obs_busy) busy_ok = 1'b0;
        if (!obs_out_valid) lat = -1;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_g = 1'b1; rst_l = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; funct = 6'b000000; shamt = 5'd3; rs = '0; rt = 32'h1;
        tick();
        tick();
        n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", obs_in_ready); end
        rst_g = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (obs_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", obs_out_valid); end
        n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", obs_busy); end
        n_tests++; if (obs_result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", obs_result); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", obs_err); end
        n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready_after: got %b expected 1", obs_in_ready); end
    endtask

    task automatic test_sra_step1();
        int lat;
        logic bok;
        sel = 1'b1; out_ready = 1'b1;
        #1;
        run_op(6'b000011, 5'd4, 32'h0, 32'h8000_0000, lat, bok);
        n_tests++; if (lat !== 5) begin n_fail++; $display("[TB] FAIL sra1_latency: got %0d expected 5", lat); end
        n_tests++; if (obs_result !== 32'hF800_0000) begin n_fail++; $display("[TB] FAIL sra1_result: got %h expected f8000000", obs_result); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sra1_err: got %b expected 0", obs_err); end
        n_tests++; if (bok !== 1'b1) begin n_fail++; $display("[TB] FAIL sra1_busy: got %b expected 1", bok); end
        tick();
        n_tests++; if (obs_out_valid !== 1'b0 || obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sra1_return_idle: got valid=%b busy=%b expected 0 0", obs_out_valid, obs_busy); end
    endtask

    task automatic test_var_shifts();
        int lat;
        logic bok;
        sel = 1'b0; out_ready = 1'b1;
        #1;
        run_op(6'b000111, 5'd0, 32'h0000_0024, 32'hF000_0000, lat, bok);
        n_tests++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL srav_latency: got %0d expected 2", lat); end
        n_tests++; if (obs_result !== 32'hFF00_0000) begin n_fail++; $display("[TB] FAIL srav_result: got %h expected ff000000", obs_result); end
        tick();
        run_op(6'b000110, 5'd0, 32'h0000_0024, 32'hF000_0000, lat, bok);
        n_tests++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL srlv_latency: got %0d expected 2", lat); end
        n_tests++; if (obs_result !== 32'h0F00_0000) begin n_fail++; $display("[TB] FAIL srlv_result: got %h expected 0f000000", obs_result); end
        tick();
    endtask

    task automatic test_long_and_zero();
        int lat;
        logic bok;
        sel = 1'b0; out_ready = 1'b1;
        run_op(6'b000010, 5'd31, 32'h0, 32'h8000_0000, lat, bok);
        n_tests++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL srl31_latency: got %0d expected 9", lat); end
        n_tests++; if (obs_result !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL srl31_result: got %h expected 00000001", obs_result); end
        tick();
        run_op(6'b000000, 5'd0, 32'h0, 32'h1234_5678, lat, bok);
        n_tests++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL sll0_latency: got %0d expected 1", lat); end
        n_tests++; if (obs_result !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL sll0_result: got %h expected 12345678", obs_result); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic bok;
        sel = 1'b0; out_ready = 1'b0;
        run_op(6'b000000, 5'd8, 32'h0, 32'h0000_0001, lat, bok);
        n_tests++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 3", lat); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; funct = 6'b000010; shamt = 5'd1; rt = 32'h0000_FFFF;
            #1;
            n_tests++; if (obs_result !== 32'h0000_0100 || obs_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold: got result=%h valid=%b expected 00000100 1", obs_result, obs_out_valid); end
            n_tests++; if (obs_in_ready !== 1'b0 || obs_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stall: got in_ready=%b busy=%b expected 0 1", obs_in_ready, obs_busy); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++; if (obs_result !== 32'h0000_0100 || obs_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release: got result=%h valid=%b expected 00000100 1", obs_result, obs_out_valid); end
        tick();
        in_valid = 1'b1; funct = 6'b000000; shamt = 5'd0; rs = '0; rt = 32'hA5A5_A5A5;
        #1;
        n_tests++; if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0 || obs_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_idle: got in_ready=%b busy=%b valid=%b expected 1 0 0", obs_in_ready, obs_busy, obs_out_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (obs_out_valid !== 1'b1 || obs_result !== 32'hA5A5_A5A5) begin n_fail++; $display("[TB] FAIL bp_next_op: got valid=%b result=%h expected 1 a5a5a5a5", obs_out_valid, obs_result); end
        tick();
    endtask

    // Starts SRA by 20 on the STEP=1 unit and aborts on the 3rd SHIFT cycle
    task automatic start_sra20();
        sel = 1'b1; out_ready = 1'b1;
        funct = 6'b000011; shamt = 5'd20; rs = '0; rt = 32'h8000_0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush();
        logic seen;
        start_sra20();
        n_tests++; if (obs_result !== 32'hE000_0000 || obs_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_mid_value: got result=%h busy=%b expected e0000000 1", obs_result, obs_busy); end
        flush = 1'b1; in_valid = 1'b1;
        #1;
        n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %b expected 0", obs_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (obs_busy !== 1'b0 || obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_idle: got busy=%b valid=%b in_ready=%b expected 0 0 1", obs_busy, obs_out_valid, obs_in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (obs_out_valid) seen = 1'b1;
            tick();
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_pulse: got %b expected 0", seen); end
        flush = 1'b1; in_valid = 1'b1; funct = 6'b000000; shamt = 5'd0;
        #1;
        n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_in_ready: got %b expected 0", obs_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_blocks_accept: got busy=%b expected 0", obs_busy); end
    endtask

    task automatic test_reset_mid();
        start_sra20();
        rst_l = 1'b1;
        tick();
        rst_l = 1'b0;
        #1;
        n_tests++; if (obs_result !== 32'h0 || obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_clear: got result=%h err=%b expected 00000000 0", obs_result, obs_err); end
        n_tests++; if (obs_busy !== 1'b0 || obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_idle: got busy=%b valid=%b in_ready=%b expected 0 0 1", obs_busy, obs_out_valid, obs_in_ready); end
    endtask

    task automatic test_illegal();
        int lat;
        logic bok;
        sel = 1'b0; out_ready = 1'b1;
        #1;
        run_op(6'h20, 5'd7, 32'h0000_001F, 32'hDEAD_BEEF, lat, bok);
        n_tests++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
        n_tests++; if (obs_err !== 1'b1 || obs_result !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL illegal_out: got err=%b result=%h expected 1 deadbeef", obs_err, obs_result); end
        tick();
        run_op(6'b000010, 5'd4, 32'h0, 32'hDEAD_BEEF, lat, bok);
        n_tests++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL legal_after_latency: got %0d expected 2", lat); end
        n_tests++; if (obs_err !== 1'b0 || obs_result !== 32'h0DEA_DBEE) begin n_fail++; $display("[TB] FAIL legal_after_out: got err=%b result=%h expected 0 0deadbee", obs_err, obs_result); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sra_step1();
        test_var_shifts();
        test_long_and_zero();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
